// File: rtl/alu_unit.sv
// alu_unit: single-cycle integer ALU for an out-of-order core. Issued ops are
// evaluated combinationally and their results parked in a small FIFO until the
// common data bus accepts them.
module alu_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _alu_ready,
    input  logic [4:0]  _alu_rob_id,
    input  logic [6:0]  _alu_type,
    input  logic [3:0]  _alu_op,
    input  logic [31:0] _alu_v1,
    input  logic [31:0] _alu_v2,
    output logic        _alu_full,
    input  logic        _cdb_hold,
    output logic        _cdb_ready,
    output logic [4:0]  _cdb_rob_id,
    output logic [31:0] _cdb_value
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    logic [4:0]    rob_q [DEPTH];
    logic [31:0]   val_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0] result;
    logic [4:0]  shamt;
    logic        push;
    logic        pop;

    assign shamt = _alu_v2[4:0];

    // Decode the issued op and compute its result in the same cycle.
    always_comb begin
        result = _alu_v1 + _alu_v2;
        case (_alu_type)
            OPC_OP, OPC_OPIMM: begin
                case (_alu_op[2:0])
                    3'b000: result = (_alu_type == OPC_OP && _alu_op[3]) ? (_alu_v1 - _alu_v2)
                                                                          : (_alu_v1 + _alu_v2);
                    3'b001: result = _alu_v1 << shamt;
                    3'b010: result = ($signed(_alu_v1) < $signed(_alu_v2)) ? 32'd1 : 32'd0;
                    3'b011: result = (_alu_v1 < _alu_v2) ? 32'd1 : 32'd0;
                    3'b100: result = _alu_v1 ^ _alu_v2;
                    3'b101: result = _alu_op[3] ? 32'($signed(_alu_v1) >>> shamt)
                                                : (_alu_v1 >> shamt);
                    3'b110: result = _alu_v1 | _alu_v2;
                    default: result = _alu_v1 & _alu_v2;
                endcase
            end
            OPC_BRANCH: begin
                case (_alu_op[2:0])
                    3'b000: result = {31'd0, _alu_v1 == _alu_v2};
                    3'b001: result = {31'd0, _alu_v1 != _alu_v2};
                    3'b100: result = {31'd0, $signed(_alu_v1) <  $signed(_alu_v2)};
                    3'b101: result = {31'd0, $signed(_alu_v1) >= $signed(_alu_v2)};
                    3'b110: result = {31'd0, _alu_v1 <  _alu_v2};
                    3'b111: result = {31'd0, _alu_v1 >= _alu_v2};
                    default: result = 32'd0;
                endcase
            end
            default: result = _alu_v1 + _alu_v2;
        endcase
    end

    assign push = _alu_ready && rdy_in && !_clear;
    assign pop  = (count_q != '0) && !_cdb_hold && rdy_in && !_clear;

    // Next-state for the queue pointers and occupancy; a flush wins over traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Register the queue state and write issued results into the tail slot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the storage is reset too, so the head entry driven onto the
            // bus reads as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                rob_q[tail_q] <= _alu_rob_id;
                val_q[tail_q] <= result;
            end
        end
    end

    assign _cdb_ready  = (count_q != '0);
    assign _cdb_rob_id = rob_q[head_q];
    assign _cdb_value  = val_q[head_q];
    assign _alu_full   = (count_q == DEPTH_C);

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed tests for alu_unit with hand-computed expected values.
module tb_alu_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_hold;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] T_R = 7'b0110011;
    localparam logic [6:0] T_I = 7'b0010011;
    localparam logic [6:0] T_B = 7'b1100011;
    localparam logic [6:0] T_X = 7'b0110111;

    typedef struct {
        logic [6:0]  t;
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] exp;
    } vec_t;

    alu_unit #(.DEPTH(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_ready  (_alu_ready),
        ._alu_rob_id (_alu_rob_id),
        ._alu_type   (_alu_type),
        ._alu_op     (_alu_op),
        ._alu_v1     (_alu_v1),
        ._alu_v2     (_alu_v2),
        ._alu_full   (_alu_full),
        ._cdb_hold   (_cdb_hold),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [6:0] t, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        _alu_ready  = 1'b1;
        _alu_type   = t;
        _alu_op     = op;
        _alu_v1     = a;
        _alu_v2     = b;
        _alu_rob_id = tag;
    endtask

    task automatic idle();
        _alu_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _cdb_hold = 1'b0;
        _alu_ready = 1'b0; _alu_rob_id = '0; _alu_type = '0; _alu_op = '0;
        _alu_v1 = '0; _alu_v2 = '0;
        step(); step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", _cdb_ready); end
        checks++; if (_alu_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", _alu_full); end
        checks++; if (_cdb_rob_id !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", _cdb_rob_id); end
        checks++; if (_cdb_value !== 32'd0) begin errors++; $display("FAIL reset_value: got %h expected 0", _cdb_value); end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_sub();
        issue(T_R, 4'b1000, 32'd5, 32'd7, 5'd3);
        step();
        idle();
        checks++; if (_cdb_ready !== 1'b1) begin errors++; $display("FAIL sub_ready: got %b expected 1", _cdb_ready); end
        checks++; if (_cdb_rob_id !== 5'd3) begin errors++; $display("FAIL sub_tag: got %0d expected 3", _cdb_rob_id); end
        checks++; if (_cdb_value !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_value: got %h expected fffffffe", _cdb_value); end
        step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL sub_popped: got %b expected 0", _cdb_ready); end
    endtask

    // Back-to-back issue with the bus free: each result sits alone at the head.
    task automatic test_ops();
        vec_t v[20];
        v[0]  = '{T_I, 4'b1101, 32'h8000_0000, 32'd4,        32'hF800_0000}; // srai
        v[1]  = '{T_I, 4'b0101, 32'h8000_0000, 32'd4,        32'h0800_0000}; // srli
        v[2]  = '{T_I, 4'b1000, 32'd1,         32'd2,        32'd3};         // addi ignores op[3]
        v[3]  = '{T_I, 4'b0010, 32'hFFFF_FFFE, 32'd1,        32'd1};         // slti
        v[4]  = '{T_B, 4'b0100, 32'hFFFF_FFFF, 32'd1,        32'd1};         // blt
        v[5]  = '{T_B, 4'b0110, 32'hFFFF_FFFF, 32'd1,        32'd0};         // bltu
        v[6]  = '{T_B, 4'b0010, 32'hFFFF_FFFF, 32'd1,        32'd0};         // funct3 010
        v[7]  = '{T_B, 4'b0000, 32'd7,         32'd7,        32'd1};         // beq
        v[8]  = '{T_B, 4'b0001, 32'd7,         32'd7,        32'd0};         // bne
        v[9]  = '{T_B, 4'b0101, 32'hFFFF_FFFF, 32'd1,        32'd0};         // bge
        v[10] = '{T_B, 4'b0111, 32'hFFFF_FFFF, 32'd1,        32'd1};         // bgeu
        v[11] = '{T_R, 4'b0000, 32'hFFFF_FFFF, 32'd2,        32'd1};         // add wraps
        v[12] = '{T_R, 4'b0001, 32'd1,         32'h21,       32'd2};         // sll uses v2[4:0]
        v[13] = '{T_R, 4'b0010, 32'hFFFF_FFFF, 32'd1,        32'd1};         // slt
        v[14] = '{T_R, 4'b0011, 32'hFFFF_FFFF, 32'd1,        32'd0};         // sltu
        v[15] = '{T_R, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0}; // xor
        v[16] = '{T_R, 4'b1101, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF}; // sra
        v[17] = '{T_R, 4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'hFFFF_FFF0}; // or
        v[18] = '{T_R, 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000}; // and
        v[19] = '{T_X, 4'b0111, 32'h10,        32'h20,       32'h30};        // other type adds
        for (int i = 0; i < 20; i++) begin
            issue(v[i].t, v[i].op, v[i].v1, v[i].v2, 5'(i + 1));
            step();
            checks++;
            if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'(i + 1) || _cdb_value !== v[i].exp) begin
                errors++;
                $display("FAIL op_vec%0d: got ready=%b tag=%0d value=%h expected ready=1 tag=%0d value=%h",
                         i, _cdb_ready, _cdb_rob_id, _cdb_value, i + 1, v[i].exp);
            end
        end
        idle();
        step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL ops_drained: got %b expected 0", _cdb_ready); end
    endtask

    task automatic test_hold_full();
        _cdb_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            issue(T_R, 4'b0000, 32'(k), 32'd100, 5'(k));
            step();
            checks++;
            if (_alu_full !== (k == 4)) begin
                errors++; $display("FAIL full_after_%0d: got %b expected %b", k, _alu_full, k == 4);
            end
        end
        idle();
        _cdb_hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'(k) || _cdb_value !== 32'(k + 100)) begin
                errors++;
                $display("FAIL order_%0d: got ready=%b tag=%0d value=%h expected ready=1 tag=%0d value=%h",
                         k, _cdb_ready, _cdb_rob_id, _cdb_value, k, k + 100);
            end
            step();
            if (k == 1) begin
                checks++; if (_alu_full !== 1'b0) begin errors++; $display("FAIL full_drop: got %b expected 0", _alu_full); end
            end
        end
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL hold_drained: got %b expected 0", _cdb_ready); end
    endtask

    task automatic test_back_to_back();
        _cdb_hold = 1'b1;
        issue(T_R, 4'b0000, 32'd5, 32'd0, 5'd5); step();
        issue(T_R, 4'b0000, 32'd6, 32'd0, 5'd6); step();
        _cdb_hold = 1'b0;
        issue(T_R, 4'b0000, 32'd7, 32'd0, 5'd7); step();   // push and pop together
        checks++; if (_cdb_rob_id !== 5'd6) begin errors++; $display("FAIL b2b_head: got %0d expected 6", _cdb_rob_id); end
        _cdb_hold = 1'b1;
        issue(T_R, 4'b0000, 32'd8, 32'd0, 5'd8); step();
        checks++; if (_alu_full !== 1'b0) begin errors++; $display("FAIL b2b_count3: got full=%b expected 0", _alu_full); end
        issue(T_R, 4'b0000, 32'd9, 32'd0, 5'd9); step();
        checks++; if (_alu_full !== 1'b1) begin errors++; $display("FAIL b2b_count4: got full=%b expected 1", _alu_full); end
        _clear = 1'b1;
        issue(T_R, 4'b0000, 32'd10, 32'd0, 5'd10); step();
        _clear = 1'b0;
        idle();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b expected 0", _cdb_ready); end
        checks++; if (_alu_full !== 1'b0) begin errors++; $display("FAIL clear_full: got %b expected 0", _alu_full); end
        step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL clear_dropped: got %b expected 0", _cdb_ready); end
        issue(T_R, 4'b0000, 32'd11, 32'd0, 5'd11); step();
        idle();
        checks++; if (_cdb_rob_id !== 5'd11 || _cdb_value !== 32'd11) begin
            errors++; $display("FAIL post_clear: got tag=%0d value=%h expected tag=11 value=b", _cdb_rob_id, _cdb_value);
        end
        _cdb_hold = 1'b0;
        step();
    endtask

    task automatic test_async_reset_and_stall();
        _cdb_hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            issue(T_R, 4'b0000, 32'd40, 32'(k), 5'(20 + k));
            step();
        end
        idle();
        #2 rst_in = 1'b1;
        #1;
        checks++;
        if (_cdb_ready !== 1'b0 || _cdb_rob_id !== 5'd0 || _cdb_value !== 32'd0 || _alu_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b tag=%0d value=%h full=%b expected all 0",
                     _cdb_ready, _cdb_rob_id, _cdb_value, _alu_full);
        end
        #1 rst_in = 1'b0;
        step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL reset_discard: got %b expected 0", _cdb_ready); end
        issue(T_R, 4'b0000, 32'd30, 32'd0, 5'd30); step();
        rdy_in = 1'b0;
        _cdb_hold = 1'b0;
        issue(T_R, 4'b0000, 32'd31, 32'd0, 5'd31); step();
        checks++;
        if (_cdb_ready !== 1'b1 || _cdb_rob_id !== 5'd30 || _cdb_value !== 32'd30) begin
            errors++; $display("FAIL stall_frozen: got ready=%b tag=%0d value=%h expected ready=1 tag=30 value=1e",
                               _cdb_ready, _cdb_rob_id, _cdb_value);
        end
        idle();
        rdy_in = 1'b1;
        step();
        checks++; if (_cdb_ready !== 1'b0) begin errors++; $display("FAIL stall_ignored_issue: got %b expected 0", _cdb_ready); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_ops();
        test_hold_full();
        test_back_to_back();
        test_async_reset_and_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result-queue entries (power of two, >=2).
REQ-002 SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL have port _clear  input  1  pipeline flush (mispredict), synchronous.
REQ-006 SHALL have port _alu_ready  input  1  issue valid from reservation station.
REQ-007 SHALL have port _alu_rob_id  input  5  ROB tag of issued op.
REQ-008 SHALL have port _alu_type  input  7  RISC-V opcode field.
REQ-009 SHALL have port _alu_op  input  4  op[2:0]=funct3, op[3]=funct7 bit5.
REQ-010 SHALL have ports _alu_v1, _alu_v2  input  32 each  operands; v2 is rs2 or imm.
REQ-011 SHALL have port _alu_full  output  1  issue blocked.
REQ-012 SHALL have port _cdb_hold  input  1  CDB cannot take a result this cycle.
REQ-013 SHALL have port _cdb_ready  output  1  result valid on CDB.
REQ-014 SHALL have ports _cdb_rob_id (5) and _cdb_value (32)  output  result tag and value.

Function
REQ-015 SHALL compute the result combinationally from issue inputs and write it, with _alu_rob_id, into the queue tail at the edge where _alu_ready && rdy_in && !_clear (issue stage guarantees _alu_ready only when !_alu_full).
REQ-016 SHALL, for type 0110011: op 0000 add, 1000 sub, x001 sll, x010 slt (signed), x011 sltu, x100 xor, 0101 srl, 1101 sra, x110 or, x111 and.
REQ-017 SHALL, for type 0010011: same as REQ-016 except op[2:0]=000 is always add and op[3] only selects srai vs srli.
REQ-018 SHALL use shift amount v2[4:0]; all arithmetic mod 2^32; slt/sltu results are 0 or 1.
REQ-019 SHALL, for type 1100011, produce 1 if taken else 0: funct3 000 eq, 001 ne, 100 lt, 101 ge (signed), 110 ltu, 111 geu (unsigned); 010/011 produce 0.
REQ-020 SHALL, for any other type, produce v1+v2.
REQ-021 SHALL drive _cdb_ready = (count!=0), _cdb_rob_id/_cdb_value = head entry, combinationally from registered state (latency: issue at edge N -> visible after edge N if queue was empty).
REQ-022 SHALL pop the head at an edge where _cdb_ready && !_cdb_hold && rdy_in && !_clear.
REQ-023 SHALL drive _alu_full = (count==DEPTH), from registered count only.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; pointers wrap modulo DEPTH.
REQ-025 SHALL preserve FIFO order; no entry dropped or duplicated while held.
REQ-026 SHALL, when rdy_in low, change no state and ignore _alu_ready; outputs stay stable.
REQ-027 SHALL, on _clear high (with rdy_in any), set count, head, tail to 0 and drop any same-cycle issue.

Reset
REQ-028 SHALL, while rst_in high, asynchronously force count=0, head=tail=0, stored entries 0, giving _cdb_ready=0, _cdb_rob_id=0, _cdb_value=0, _alu_full=0.
REQ-029 SHALL take reset priority over _clear and rdy_in; reset mid-operation discards all queued results.

Verification
REQ-030 SHALL cover: issue type 0110011 op 1000 v1=5 v2=7 tag 3, hold=0 -> next cycle _cdb_ready=1, tag 3, value 0xFFFFFFFE; popped the cycle after.
REQ-031 SHALL cover: type 0010011 op 1101 v1=0x80000000 v2=4 -> 0xF8000000; op 0101 -> 0x08000000; op 1000 v1=1 v2=2 -> 3 (addi).
REQ-032 SHALL cover: type 1100011 op 0100 v1=-1 v2=1 -> 1; op 0110 same operands -> 0; op 0010 -> 0.
REQ-033 SHALL cover: _cdb_hold=1 with 4 issues tags 1..4 -> _alu_full=1 after 4th edge; release hold -> tags 1,2,3,4 emitted in order, _alu_full drops after first pop.
REQ-034 SHALL cover: queue 2 entries, simultaneous issue and pop -> count stays 2; then _clear with issue asserted -> _cdb_ready=0, issued op absent.
REQ-035 SHALL cover: rst_in pulsed between clock edges with 3 queued -> outputs 0 immediately; rdy_in=0 with issue asserted -> no state change for that cycle.
